hex_display_mux: RTL and testbench

HEX_DISPLAY_MUX -- requirements
Module: hex_display_mux

---
 rtl/hex_display_pkg.sv | 23 ++
 rtl/hex_seg_decode.sv | 11 +
 rtl/hex_display_mux.sv | 143 ++++++++++++++
 tb/tb_hex_display_mux.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display multiplexer: segment table, blank code
// and legal parameter ranges.
package hex_display_pkg;

    localparam int DIGITS_MIN       = 1;
    localparam int DIGITS_MAX       = 8;
    localparam int PRESCALE_MIN     = 2;
    localparam int BLINK_FRAMES_MIN = 1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low, seg[0]=a ... seg[6]=g.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Counter width that never collapses to zero bits.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_seg_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/hex_display_mux.sv
// Time-multiplexed hex display driver with frame-synchronous data update,
// leading-zero blanking and whole-display blinking.
module hex_display_mux
    import hex_display_pkg::*;
#(
    parameter int DIGITS       = 6,
    parameter int PRESCALE     = 50000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  blank_lz,
    input  logic                  blink_en,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_done
);

    localparam int IW = width_of(DIGITS);
    localparam int PW = width_of(PRESCALE);
    localparam int BW = width_of(BLINK_FRAMES);

    generate
        if (DIGITS < DIGITS_MIN || DIGITS > DIGITS_MAX ||
            PRESCALE < PRESCALE_MIN || BLINK_FRAMES < BLINK_FRAMES_MIN) begin : g_bad_param
            $error("hex_display_mux: parameter out of range");
        end
    endgenerate

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   pend_q, pend_d;
    logic [4*DIGITS-1:0]   act_q, act_d;
    logic                  pflag_q, pflag_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic                  phase_q, phase_d;
    logic [6:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     dig_q, dig_d;
    logic                  fdone_q, fdone_d;

    logic                  tick, frame;
    logic [DIGITS-1:0]     lz_mask;
    logic                  zero_above, sel_lz;
    logic [3:0]            sel_nib;
    logic [6:0]            dec_seg;

    hex_seg_decode u_dec (
        .nib_i (sel_nib),
        .seg_o (dec_seg)
    );

    // lz_mask[i] is set when nibble i and every nibble above it are zero.
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (act_q[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_above;
        end
        sel_nib = act_q[3:0];
        sel_lz  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                sel_nib = act_q[4*i +: 4];
                sel_lz  = lz_mask[i];
            end
        end
    end

    always_comb begin
        tick    = (presc_q == PW'(PRESCALE - 1));
        frame   = tick && (idx_q == IW'(DIGITS - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        pend_d  = pend_q;
        act_d   = act_q;
        pflag_d = pflag_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;

        if (tick)
            idx_d = frame ? '0 : idx_q + IW'(1);

        // Boundary transfer comes first so a coincident load re-arms the flag.
        if (frame && pflag_q) begin
            act_d   = pend_q;
            pflag_d = 1'b0;
        end
        if (load) begin
            pend_d  = data;
            pflag_d = 1'b1;
        end

        // Blink timing is frozen while blinking is disabled.
        if (frame && blink_en) begin
            if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d  = bcnt_q + BW'(1);
            end
        end

        fdone_d = frame;
        dig_d   = ~(DIGITS'(1) << idx_q);
        seg_d   = dec_seg;
        if ((blank_lz && sel_lz) || (blink_en && phase_q))
            seg_d = SEG_BLANK;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            pend_q  <= '0;
            act_q   <= '0;
            pflag_q <= 1'b0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            seg_q   <= SEG_BLANK;
            dig_q   <= '1;
            fdone_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            pflag_q <= pflag_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            fdone_q <= fdone_d;
        end
    end

    assign seg        = seg_q;
    assign dig_en     = dig_q;
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_hex_display_mux.sv
// Randomized and directed bench for hex_display_mux against a cycle-count
// based behavioural model (DIGITS=4, PRESCALE=4, BLINK_FRAMES=2).
module tb_hex_display_mux;

    localparam int D  = 4;
    localparam int PS = 4;
    localparam int BF = 2;
    localparam int FRAME = D * PS;

    logic          clock;
    logic          reset;
    logic          load;
    logic [15:0]   data;
    logic          blank_lz;
    logic          blink_en;
    logic [6:0]    seg;
    logic [3:0]    dig_en;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    hex_display_mux #(.DIGITS(D), .PRESCALE(PS), .BLINK_FRAMES(BF)) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .data       (data),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .seg        (seg),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model state: cycles since reset release plus the data/blink registers.
    int          m_c;
    logic [15:0] m_pend, m_act;
    bit          m_pflag, m_phase, m_valid;
    int          m_fcnt;
    logic [6:0]  e_seg;
    logic [3:0]  e_dig;
    logic        e_fd;

    function automatic logic [6:0] hexseg(input int n);
        case (n)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
           12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int idx, v;
        bit fr;
        if (reset) begin
            m_c = 0; m_pend = 0; m_act = 0; m_pflag = 0;
            m_fcnt = 0; m_phase = 0; m_valid = 1;
            e_seg = 7'h7F; e_dig = 4'hF; e_fd = 1'b0;
        end else begin
            idx   = (m_c / PS) % D;
            v     = int'(m_act) >> (4 * idx);
            e_dig = ~(4'b0001 << idx);
            if (blink_en && m_phase)             e_seg = 7'h7F;
            else if (blank_lz && idx != 0 && v == 0) e_seg = 7'h7F;
            else                                 e_seg = hexseg(v & 15);
            fr   = (m_c % FRAME) == FRAME - 1;
            e_fd = fr;
            if (fr && m_pflag) begin m_act = m_pend; m_pflag = 0; end
            if (load) begin m_pend = data; m_pflag = 1; end
            if (fr && blink_en) begin
                m_fcnt++;
                if (m_fcnt == BF) begin m_fcnt = 0; m_phase = !m_phase; end
            end
            m_c++;
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clock);
        model_update();
        @(negedge clock);
        if (m_valid) begin
            chk("seg", {9'd0, seg}, {9'd0, e_seg});
            chk("dig_en", {12'd0, dig_en}, {12'd0, e_dig});
            chk("frame_done", {15'd0, frame_done}, {15'd0, e_fd});
        end
    endtask

    task automatic wait_frame();
        bit seen = 0;
        for (int k = 0; k < 3 * FRAME && !seen; k++) begin
            step();
            seen = frame_done;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_frame: no frame_done within %0d cycles", 3 * FRAME);
        end
    endtask

    // Called right after a frame_done sample: checks each digit of the next frame.
    task automatic show_frame(input logic [6:0] s0, s1, s2, s3);
        step();          chk("frm_d0", {9'd0, seg}, {9'd0, s0});
        repeat (PS) step(); chk("frm_d1", {9'd0, seg}, {9'd0, s1});
        repeat (PS) step(); chk("frm_d2", {9'd0, seg}, {9'd0, s2});
        repeat (PS) step(); chk("frm_d3", {9'd0, seg}, {9'd0, s3});
    endtask

    initial begin
        m_valid = 0;
        reset = 1; load = 1; data = 16'hFFFF; blank_lz = 0; blink_en = 0;
        @(negedge clock);
        step(); step();
        chk("rst_seg", {9'd0, seg}, 16'h007F);
        chk("rst_dig", {12'd0, dig_en}, 16'h000F);
        chk("rst_fd", {15'd0, frame_done}, 16'h0000);
        reset = 0; load = 0;
        step();
        chk("rel_seg", {9'd0, seg}, 16'h0040);
        chk("rel_dig", {12'd0, dig_en}, 16'h000E);
        repeat (PS) step(); chk("rot_D", {12'd0, dig_en}, 16'h000D);
        repeat (PS) step(); chk("rot_B", {12'd0, dig_en}, 16'h000B);
        repeat (PS) step(); chk("rot_7", {12'd0, dig_en}, 16'h0007);

        // Mid-frame load stays hidden until the boundary.
        load = 1; data = 16'h12AF;
        step();
        load = 0;
        chk("hold_old", {9'd0, seg}, 16'h0040);
        wait_frame();
        show_frame(7'h0E, 7'h08, 7'h24, 7'h79);
        wait_frame();

        blank_lz = 1; load = 1; data = 16'h00B0;
        step(); load = 0;
        wait_frame();
        show_frame(7'h40, 7'h03, 7'h7F, 7'h7F);
        wait_frame();
        load = 1; data = 16'h0000;
        step(); load = 0;
        wait_frame();
        show_frame(7'h40, 7'h7F, 7'h7F, 7'h7F);
        wait_frame();

        // Load landing on the boundary tick while another value is pending.
        blank_lz = 0; load = 1; data = 16'h1111;
        step(); load = 0;
        repeat (FRAME - 2) step();
        load = 1; data = 16'h5555;
        step(); load = 0;
        chk("bnd_fd", {15'd0, frame_done}, 16'h0001);
        show_frame(7'h79, 7'h79, 7'h79, 7'h79);
        wait_frame();
        show_frame(7'h12, 7'h12, 7'h12, 7'h12);
        wait_frame();

        blink_en = 1;
        show_frame(7'h12, 7'h12, 7'h12, 7'h12); wait_frame();
        show_frame(7'h12, 7'h12, 7'h12, 7'h12); wait_frame();
        show_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F); wait_frame();
        show_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F); wait_frame();
        show_frame(7'h12, 7'h12, 7'h12, 7'h12); wait_frame();
        blink_en = 0;

        for (int n = 0; n < 1500; n++) begin
            load  = ($urandom_range(0, 7) == 0);
            data  = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 99) == 0) blink_en = ~blink_en;
            step();
        end
        reset = 0; load = 0; blank_lz = 0; blink_en = 0;

        // Reset mid-frame with data pending discards it.
        wait_frame();
        load = 1; data = 16'hABCD;
        step(); load = 0;
        step();
        reset = 1;
        step();
        chk("mid_rst_seg", {9'd0, seg}, 16'h007F);
        chk("mid_rst_dig", {12'd0, dig_en}, 16'h000F);
        reset = 0;
        step();
        chk("mid_rel_seg", {9'd0, seg}, 16'h0040);
        chk("mid_rel_dig", {12'd0, dig_en}, 16'h000E);
        wait_frame();
        show_frame(7'h40, 7'h40, 7'h40, 7'h40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
